// File: rtl/register_file_mch.sv
// Micro-facing register file: decodes GPIO command words, drives datapath controls and a timed
// soft reset, and returns capture channels or status. REGFILE_READBACK_EN adds scratch/status regs.
module register_file_mch #(
  parameter int unsigned NB_GPIOS            = 32,
  parameter int unsigned NB_GPIO_ADDRESS     = 8,
  parameter int unsigned NB_GPIO_DATA        = 23,
  parameter int unsigned N_CAPTURE_CH        = 4,
  parameter int unsigned NB_ENABLE_TOTAL     = 4,
  parameter int unsigned NB_LOG_READ_DEVICES = 2,
  parameter int unsigned SOFT_RESET_HOLD     = 16
) (
  input  logic                             clock,
  input  logic                             in_reset_n,
  input  logic [NB_GPIOS-1:0]              in_micro_to_rf_data,
  input  logic [N_CAPTURE_CH*NB_GPIOS-1:0] in_log_capture_data,
  output logic [NB_GPIOS-1:0]              out_rf_to_micro_data,
  output logic                             out_soft_reset,
  output logic [NB_ENABLE_TOTAL-1:0]       out_enables_module,
  output logic                             log_ram_run_from_micro,
  output logic [NB_LOG_READ_DEVICES-1:0]   log_read_devices
);

  localparam logic [NB_GPIO_ADDRESS-1:0] AddrSel     = NB_GPIO_ADDRESS'(8'h00);
  localparam logic [NB_GPIO_ADDRESS-1:0] AddrSoftRst = NB_GPIO_ADDRESS'(8'h01);
  localparam logic [NB_GPIO_ADDRESS-1:0] AddrEnable  = NB_GPIO_ADDRESS'(8'h02);
  localparam logic [NB_GPIO_ADDRESS-1:0] AddrLogRun  = NB_GPIO_ADDRESS'(8'h06);
  localparam logic [NB_GPIO_ADDRESS-1:0] AddrLogDev  = NB_GPIO_ADDRESS'(8'h07);
  localparam logic [NB_GPIO_ADDRESS-1:0] AddrScratch = NB_GPIO_ADDRESS'(8'h08);
  localparam logic [NB_GPIO_ADDRESS-1:0] AddrClear   = NB_GPIO_ADDRESS'(8'h09);

  localparam logic [15:0] HoldLoad = 16'(SOFT_RESET_HOLD);

  // Input stage and edge detection
  logic [NB_GPIOS-1:0]            r_cmd;
  logic                           r_en_prev;
  logic                           r_cmd_fresh;

  // Control registers
  logic [NB_GPIO_ADDRESS-1:0]     r_return_select;
  logic                           r_soft_reset;
  logic [15:0]                    r_hold_cnt;
  logic [NB_ENABLE_TOTAL-1:0]     r_enables;
  logic                           r_log_run;
  logic [NB_LOG_READ_DEVICES-1:0] r_log_dev;
  logic [NB_GPIOS-1:0]            r_rdata;

  logic [NB_GPIO_ADDRESS-1:0]     w_addr;
  logic                           w_we;
  logic [NB_GPIO_DATA-1:0]        w_data;
  logic                           w_commit;
  logic                           w_en_prev_d;

  logic [NB_GPIO_ADDRESS-1:0]     w_return_select_d;
  logic                           w_soft_reset_d;
  logic [15:0]                    w_hold_cnt_d;
  logic [NB_ENABLE_TOTAL-1:0]     w_enables_d;
  logic                           w_log_run_d;
  logic [NB_LOG_READ_DEVICES-1:0] w_log_dev_d;
  logic [NB_GPIOS-1:0]            w_rdata;

`ifdef REGFILE_READBACK_EN
  localparam logic [NB_GPIO_ADDRESS-1:0] SelCtrl    = NB_GPIO_ADDRESS'(8'h80);
  localparam logic [NB_GPIO_ADDRESS-1:0] SelScratch = NB_GPIO_ADDRESS'(8'h81);
  localparam logic [NB_GPIO_ADDRESS-1:0] SelStatus  = NB_GPIO_ADDRESS'(8'h82);

  logic [NB_GPIO_DATA-1:0] r_scratch;
  logic [15:0]             r_write_cnt;
  logic                    r_bad_addr;
  logic [NB_GPIO_DATA-1:0] w_scratch_d;
  logic [15:0]             w_write_cnt_d;
  logic                    w_bad_addr_d;
  logic                    w_counted;
  logic [31:0]             w_ctrl_word;
`else
  logic w_unused_data;
  assign w_unused_data = ^w_data;
`endif

  assign w_addr   = r_cmd[NB_GPIOS-1 -: NB_GPIO_ADDRESS];
  assign w_we     = r_cmd[NB_GPIO_DATA];
  assign w_data   = r_cmd[NB_GPIO_DATA-1:0];
  assign w_commit = w_we & ~r_en_prev;

  // cmd_q still holds its reset value on the first edge after reset; keep en_prev high across
  // it so an enable held through reset needs a fresh low->high before it commits.
  assign w_en_prev_d = r_cmd_fresh ? r_en_prev : w_we;

  always_comb begin
    w_return_select_d = r_return_select;
    w_soft_reset_d    = r_soft_reset;
    w_hold_cnt_d      = r_hold_cnt;
    w_enables_d       = r_enables;
    w_log_run_d       = r_log_run;
    w_log_dev_d       = r_log_dev;
`ifdef REGFILE_READBACK_EN
    w_scratch_d       = r_scratch;
    w_write_cnt_d     = r_write_cnt;
    w_bad_addr_d      = r_bad_addr;
    w_counted         = 1'b0;
`endif

    if (r_hold_cnt != 16'd0) begin
      w_hold_cnt_d = r_hold_cnt - 16'd1;
      if (r_hold_cnt == 16'd1) begin
        w_soft_reset_d = 1'b0;
      end
    end

    if (w_commit) begin
      case (w_addr)
        AddrSel: begin
          w_return_select_d = w_data[NB_GPIO_ADDRESS-1:0];
`ifdef REGFILE_READBACK_EN
          w_counted = 1'b1;
`endif
        end
        AddrSoftRst: begin
          // A write here overrides the running countdown, so a rewrite extends the pulse.
          w_soft_reset_d = w_data[0];
          w_hold_cnt_d   = w_data[0] ? HoldLoad : 16'd0;
`ifdef REGFILE_READBACK_EN
          w_counted = 1'b1;
`endif
        end
        AddrEnable: begin
          w_enables_d = w_data[NB_ENABLE_TOTAL-1:0];
`ifdef REGFILE_READBACK_EN
          w_counted = 1'b1;
`endif
        end
        AddrLogRun: begin
          w_log_run_d = w_data[0];
`ifdef REGFILE_READBACK_EN
          w_counted = 1'b1;
`endif
        end
        AddrLogDev: begin
          w_log_dev_d = w_data[NB_LOG_READ_DEVICES-1:0];
`ifdef REGFILE_READBACK_EN
          w_counted = 1'b1;
`endif
        end
        AddrScratch: begin
`ifdef REGFILE_READBACK_EN
          w_scratch_d = w_data;
          w_counted   = 1'b1;
`endif
        end
        AddrClear: begin
`ifdef REGFILE_READBACK_EN
          w_write_cnt_d = 16'd0;
          w_bad_addr_d  = 1'b0;
`endif
        end
        default: begin
`ifdef REGFILE_READBACK_EN
          w_bad_addr_d = 1'b1;
`endif
        end
      endcase
`ifdef REGFILE_READBACK_EN
      if (w_counted && (r_write_cnt != 16'hFFFF)) begin
        w_write_cnt_d = r_write_cnt + 16'd1;
      end
`endif
    end
  end

`ifdef REGFILE_READBACK_EN
  always_comb begin
    w_ctrl_word        = 32'd0;
    w_ctrl_word[7:0]   = 8'(r_enables);
    w_ctrl_word[8]     = r_soft_reset;
    w_ctrl_word[9]     = r_log_run;
    w_ctrl_word[23:16] = 8'(r_log_dev);
  end
`endif

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < N_CAPTURE_CH; k++) begin
      if (r_return_select == NB_GPIO_ADDRESS'(k)) begin
        w_rdata = in_log_capture_data[k*NB_GPIOS +: NB_GPIOS];
      end
    end
`ifdef REGFILE_READBACK_EN
    case (r_return_select)
      SelCtrl:    w_rdata = NB_GPIOS'(w_ctrl_word);
      SelScratch: w_rdata = NB_GPIOS'({9'd0, r_scratch});
      SelStatus:  w_rdata = NB_GPIOS'({15'd0, r_bad_addr, r_write_cnt});
      default:    ;
    endcase
`endif
  end

  always_ff @(posedge clock) begin
    if (!in_reset_n) begin
      r_cmd           <= '0;
      r_en_prev       <= 1'b1;
      r_cmd_fresh     <= 1'b1;
      r_return_select <= '0;
      r_soft_reset    <= 1'b1;
      r_hold_cnt      <= 16'd0;
      r_enables       <= '0;
      r_log_run       <= 1'b0;
      r_log_dev       <= '0;
      r_rdata         <= '0;
    end else begin
      r_cmd           <= in_micro_to_rf_data;
      r_en_prev       <= w_en_prev_d;
      r_cmd_fresh     <= 1'b0;
      r_return_select <= w_return_select_d;
      r_soft_reset    <= w_soft_reset_d;
      r_hold_cnt      <= w_hold_cnt_d;
      r_enables       <= w_enables_d;
      r_log_run       <= w_log_run_d;
      r_log_dev       <= w_log_dev_d;
      r_rdata         <= w_rdata;
    end
  end

`ifdef REGFILE_READBACK_EN
  always_ff @(posedge clock) begin
    if (!in_reset_n) begin
      r_scratch   <= '0;
      r_write_cnt <= 16'd0;
      r_bad_addr  <= 1'b0;
    end else begin
      r_scratch   <= w_scratch_d;
      r_write_cnt <= w_write_cnt_d;
      r_bad_addr  <= w_bad_addr_d;
    end
  end
`endif

  assign out_rf_to_micro_data   = r_rdata;
  assign out_soft_reset         = r_soft_reset;
  assign out_enables_module     = r_enables;
  assign log_ram_run_from_micro = r_log_run;
  assign log_read_devices       = r_log_dev;

endmodule
